// File: rtl/barrett_pkg.sv
// Shared constants and elaboration-time helpers for the Barrett reduction pipeline.
package barrett_pkg;

  localparam int unsigned DEF_Q     = 1481;
  localparam int unsigned DEF_K     = 11;
  localparam int unsigned DEF_IN_W  = 21;
  localparam int unsigned DEF_TAG_W = 4;

  localparam int unsigned QH_W = DEF_IN_W + 1;
  localparam int unsigned R_W  = DEF_K + 2;

  function automatic int unsigned barrett_qh_w(input int unsigned in_w);
    return in_w + 1;
  endfunction

  function automatic int unsigned barrett_r_w(input int unsigned k);
    return k + 2;
  endfunction

  // MU = floor(2^(2K) / Q), fits in K+1 bits when 2^(K-1) < Q < 2^K.
  function automatic int unsigned barrett_mu(input int unsigned q, input int unsigned k);
    longint unsigned num;
    num = 64'd1 << (2 * k);
    return 32'(num / longint'(q));
  endfunction

  function automatic bit barrett_params_ok(input int unsigned q, input int unsigned k,
                                           input int unsigned in_w);
    longint unsigned lo;
    longint unsigned hi;
    if (k < 2) return 1'b0;
    lo = 64'd1 << (k - 1);
    hi = 64'd1 << k;
    return (longint'(q) > lo) && (longint'(q) < hi) && (in_w <= 2 * k);
  endfunction

endpackage

// File: rtl/barrett_reduce_pipe_corr.sv
// Two-step conditional subtract: maps r in [0, 3Q) onto [0, Q).
module barrett_corr
  import barrett_pkg::*;
#(
  parameter int unsigned Q  = DEF_Q,
  parameter int unsigned K  = DEF_K,
  parameter int unsigned RW = R_W
) (
  input  logic [RW-1:0] i_r,
  output logic [K-1:0]  o_r
);

  localparam logic [RW-1:0] QR = RW'(Q);

  logic [RW-1:0] w_s1;
  logic [RW-1:0] w_s2;

  always_comb begin
    w_s1 = (i_r >= QR) ? (i_r - QR) : i_r;
    w_s2 = (w_s1 >= QR) ? (w_s1 - QR) : w_s1;
    o_r  = K'(w_s2);
  end

endmodule

// File: rtl/barrett_reduce_pipe.sv
// Three-stage Barrett reducer, dout = din mod Q, with valid/ready flow control and a tag.
module barrett_reduce_pipe
  import barrett_pkg::*;
#(
  parameter int unsigned Q     = DEF_Q,
  parameter int unsigned K     = DEF_K,
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned TAG_W = DEF_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  din,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [K-1:0]     dout,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned QhW   = barrett_qh_w(IN_W);
  localparam int unsigned RW    = barrett_r_w(K);
  localparam int unsigned MuInt = barrett_mu(Q, K);
  localparam logic [K:0]  MU    = MuInt[K:0];

  if (!barrett_params_ok(Q, K, IN_W)) begin : g_param_err
    $error("barrett_reduce_pipe: need 2^(K-1) < Q < 2^K and IN_W <= 2*K");
  end

  logic             w_en;
  logic [QhW-1:0]   w_qh;
  logic [RW-1:0]    w_t2;
  logic [RW-1:0]    w_r2;
  logic [K-1:0]     w_corr;

  logic             r_v1, r_v2, r_v3;
  logic [RW-1:0]    r_a1;
  logic [QhW-1:0]   r_qhat1;
  logic [TAG_W-1:0] r_tag1, r_tag2, r_tag3;
  logic [RW-1:0]    r_r2;
  logic [K-1:0]     r_dout;

  assign w_en      = !r_v3 || out_ready;
  assign in_ready  = w_en || rst;
  assign out_valid = r_v3;
  assign dout      = r_dout;
  assign out_tag   = r_tag3;

  // Only the low K+2 bits of a and q*Q matter: the true remainder is below 3Q < 2^(K+2).
  assign w_qh = QhW'(din >> K) * QhW'(MU);
  assign w_t2 = RW'(r_qhat1) * RW'(Q);
  assign w_r2 = r_a1 - w_t2;

  barrett_corr #(
    .Q  (Q),
    .K  (K),
    .RW (RW)
  ) u_corr (
    .i_r (r_r2),
    .o_r (w_corr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_a1    <= '0;
      r_qhat1 <= '0;
      r_tag1  <= '0;
      r_r2    <= '0;
      r_tag2  <= '0;
      r_dout  <= '0;
      r_tag3  <= '0;
    end else if (w_en) begin
      r_v1    <= in_valid;
      r_a1    <= RW'(din);
      r_qhat1 <= w_qh >> K;
      r_tag1  <= in_tag;
      r_v2    <= r_v1;
      r_r2    <= w_r2;
      r_tag2  <= r_tag1;
      r_v3    <= r_v2;
      r_dout  <= w_corr;
      r_tag3  <= r_tag2;
    end
  end

endmodule
